// File: rtl/mmio_buttons_pkg.sv
// rtl/mmio_buttons_pkg.sv - shared constants and register selectors for the button MMIO block
package mmio_buttons_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0800;
  localparam int          DEFAULT_DEBOUNCE  = 16;
  localparam int          COUNT_W           = 16;

  // Encodings are the word offsets within the 16-byte window (byte offset >> 2).
  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_PRESS = 2'd1,
    REG_COUNT = 2'd2,
    REG_LEDS  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/mmio_buttons_if.sv
// rtl/mmio_buttons_if.sv - CPU load/store bus seen by the button register window
interface mmio_buttons_if;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        hit;

  modport master (output addr, output writedata, output memwrite,
                  input  readdata, input hit);
  modport slave  (input  addr, input  writedata, input  memwrite,
                  output readdata, output hit);
endinterface

// File: rtl/mmio_buttons_btn_debounce.sv
// rtl/mmio_buttons_btn_debounce.sv - one button: 2-flop synchronizer, stability counter, debounced level
module btn_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int             CW   = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync;

  assign sync = sync_q[1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Rise is flagged on the same edge the debounced level flips, so PRESS/COUNT track STATE exactly.
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/mmio_buttons.sv
// rtl/mmio_buttons.sv - memory-mapped debounced buttons with press latch, press counter and LED register
module mmio_buttons
  import mmio_buttons_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          N_BTN     = 4,
  parameter int          DEBOUNCE  = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset,
  mmio_buttons_if.slave    bus,
  input  logic [N_BTN-1:0] btn,
  output logic [7:0]       leds
);

  logic [31:0]        offset;
  reg_sel_e           sel;
  logic               wr_en;
  logic [N_BTN-1:0]   stable, rise;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [COUNT_W-1:0] count_q, count_d, rise_cnt;
  logic [7:0]         leds_q, leds_d;
  logic               unused_bits;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

  // Offset compare keeps the window correct even when BASE_ADDR is not 16-byte aligned.
  assign offset  = bus.addr - BASE_ADDR;
  assign bus.hit = (bus.addr >= BASE_ADDR) && (offset < 32'd16);
  assign sel     = reg_sel_e'(offset[3:2]);
  assign wr_en   = bus.memwrite && bus.hit;

  assign unused_bits = ^{bus.writedata[31:8], offset[1:0]};

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rise_cnt = rise_cnt + COUNT_W'(rise[i]);
    end
  end

  always_comb begin
    press_d = press_q;
    count_d = count_q;
    leds_d  = leds_q;
    if (wr_en) begin
      case (sel)
        REG_PRESS: press_d = press_q & ~bus.writedata[N_BTN-1:0];
        REG_COUNT: count_d = '0;
        REG_LEDS:  leds_d  = bus.writedata[7:0];
        default:   ;
      endcase
    end
    press_d = press_d | rise;
    count_d = count_d + rise_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= '0;
      count_q <= '0;
      leds_q  <= '0;
    end else begin
      press_q <= press_d;
      count_q <= count_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.hit) begin
      case (sel)
        REG_STATE: bus.readdata = 32'(stable);
        REG_PRESS: bus.readdata = 32'(press_q);
        REG_COUNT: bus.readdata = 32'(count_q);
        REG_LEDS:  bus.readdata = 32'(leds_q);
        default:   bus.readdata = '0;
      endcase
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_mmio_buttons.sv
// tb/tb_mmio_buttons.sv - scoreboard bench for mmio_buttons
module tb_mmio_buttons;

  localparam logic [31:0] BASE  = 32'h0000_0800;
  localparam logic [31:0] BASE8 = 32'h0000_2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = '0;
  logic [7:0] btn8 = '0;
  logic [7:0] leds, leds8;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  mmio_buttons_if bus();
  mmio_buttons_if bus8();

  mmio_buttons #(.BASE_ADDR(BASE), .N_BTN(4), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .btn(btn), .leds(leds)
  );

  mmio_buttons #(.BASE_ADDR(BASE8), .N_BTN(8), .DEBOUNCE(2)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .btn(btn8), .leds(leds8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string n, input logic [31:0] v);
    exp_q.push_back(v);
    nm_q.push_back(n);
  endtask

  task automatic rd(input bit u8, input logic [31:0] a);
    logic [31:0] got, e;
    string n;
    if (u8) bus8.addr = a; else bus.addr = a;
    #1;
    got = u8 ? bus8.readdata : bus.readdata;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: readdata=%h with no expectation queued", got);
    end else begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: readdata=%h expected %h", n, got, e);
      end
    end
  endtask

  task automatic wr(input bit u8, input logic [31:0] a, input logic [31:0] d);
    if (u8) begin
      bus8.addr = a; bus8.writedata = d; bus8.memwrite = 1'b1;
    end else begin
      bus.addr = a; bus.writedata = d; bus.memwrite = 1'b1;
    end
    tick();
    bus.memwrite  = 1'b0;
    bus8.memwrite = 1'b0;
  endtask

  task automatic do_reset();
    btn = '0;
    btn8 = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++;
    if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: leds=%h expected 00", leds); end
    expect_rd("reset_state", 32'h0); rd(0, BASE + 32'h0);
    expect_rd("reset_press", 32'h0); rd(0, BASE + 32'h4);
    expect_rd("reset_count", 32'h0); rd(0, BASE + 32'h8);
    expect_rd("reset_leds",  32'h0); rd(0, BASE + 32'hC);
    checks++;
    if (bus.hit !== 1'b1) begin errors++; $display("FAIL reset_hit: hit=%b expected 1", bus.hit); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_press_latency();
    do_reset();
    btn = 4'b0001;
    repeat (5) tick();
    expect_rd("lat_state_edge5", 32'h0); rd(0, BASE + 32'h0);
    expect_rd("lat_press_edge5", 32'h0); rd(0, BASE + 32'h4);
    tick();
    expect_rd("lat_state_edge6", 32'h1); rd(0, BASE + 32'h0);
    expect_rd("lat_press_edge6", 32'h1); rd(0, BASE + 32'h4);
    expect_rd("lat_count_edge6", 32'h1); rd(0, BASE + 32'h8);
    btn = 4'b0000;
    repeat (8) tick();
    expect_rd("lat_state_release", 32'h0); rd(0, BASE + 32'h0);
    expect_rd("lat_press_sticky",  32'h1); rd(0, BASE + 32'h4);
  endtask

  task automatic test_glitch();
    do_reset();
    btn = 4'b0010;
    repeat (3) tick();
    btn = 4'b0000;
    repeat (10) tick();
    expect_rd("glitch_state", 32'h0); rd(0, BASE + 32'h0);
    expect_rd("glitch_press", 32'h0); rd(0, BASE + 32'h4);
    expect_rd("glitch_count", 32'h0); rd(0, BASE + 32'h8);
  endtask

  task automatic test_w1c();
    do_reset();
    btn = 4'b0101;
    repeat (6) tick();
    expect_rd("w1c_press_set", 32'h5); rd(0, BASE + 32'h4);
    btn = 4'b0000;
    repeat (8) tick();
    wr(0, BASE + 32'h4, 32'h1);
    expect_rd("w1c_press_clr", 32'h4); rd(0, BASE + 32'h4);
    btn = 4'b0001;
    repeat (5) tick();
    wr(0, BASE + 32'h4, 32'h1);
    expect_rd("w1c_set_wins",  32'h5); rd(0, BASE + 32'h4);
    expect_rd("w1c_state",     32'h1); rd(0, BASE + 32'h0);
    expect_rd("w1c_count",     32'h3); rd(0, BASE + 32'h8);
    wr(0, BASE + 32'h0, 32'hF);
    expect_rd("state_ro",      32'h1); rd(0, BASE + 32'h0);
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_leds();
    do_reset();
    wr(0, BASE + 32'hC, 32'h0000_00A5);
    checks++;
    if (leds !== 8'hA5) begin errors++; $display("FAIL leds_out: leds=%h expected a5", leds); end
    expect_rd("leds_readback", 32'hA5); rd(0, BASE + 32'hC);
    expect_rd("leds_unaligned", 32'hA5); rd(0, BASE + 32'hF);
    expect_rd("miss_above", 32'h0); rd(0, BASE + 32'h10);
    checks++;
    if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_above: hit=%b expected 0", bus.hit); end
    expect_rd("miss_below", 32'h0); rd(0, BASE - 32'h4);
    checks++;
    if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_below: hit=%b expected 0", bus.hit); end
    wr(0, BASE + 32'h1C, 32'h0000_00FF);
    checks++;
    if (leds !== 8'hA5) begin errors++; $display("FAIL leds_miss_write: leds=%h expected a5", leds); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(0, BASE + 32'hC, 32'h0000_005A);
    btn = 4'b0011;
    repeat (6) tick();
    expect_rd("mid_pre_state", 32'h3); rd(0, BASE + 32'h0);
    btn = 4'b0111;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (leds !== 8'h00) begin errors++; $display("FAIL mid_leds_async: leds=%h expected 00", leds); end
    expect_rd("mid_rst_state", 32'h0); rd(0, BASE + 32'h0);
    expect_rd("mid_rst_press", 32'h0); rd(0, BASE + 32'h4);
    expect_rd("mid_rst_count", 32'h0); rd(0, BASE + 32'h8);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    expect_rd("mid_state_edge5", 32'h0); rd(0, BASE + 32'h0);
    tick();
    expect_rd("mid_state_edge6", 32'h7); rd(0, BASE + 32'h0);
    expect_rd("mid_count_edge6", 32'h3); rd(0, BASE + 32'h8);
    expect_rd("mid_leds_after",  32'h0); rd(0, BASE + 32'hC);
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int r = 0; r < 8191; r++) begin
      btn8 = 8'hFF; repeat (2) tick();
      btn8 = 8'h00; repeat (2) tick();
    end
    btn8 = 8'h7F; repeat (2) tick();
    btn8 = 8'h00; repeat (8) tick();
    expect_rd("count_ffff", 32'h0000_FFFF); rd(1, BASE8 + 32'h8);
    btn8 = 8'h01; repeat (2) tick();
    btn8 = 8'h00; repeat (8) tick();
    expect_rd("count_wrap", 32'h0); rd(1, BASE8 + 32'h8);
    btn8 = 8'h02; repeat (2) tick();
    btn8 = 8'h00; repeat (8) tick();
    expect_rd("count_one", 32'h1); rd(1, BASE8 + 32'h8);
    btn8 = 8'h0C;
    repeat (3) tick();
    wr(1, BASE8 + 32'h8, 32'h0);
    expect_rd("count_clr_rise", 32'h2); rd(1, BASE8 + 32'h8);
    expect_rd("count8_state", 32'h0C); rd(1, BASE8 + 32'h0);
    btn8 = 8'h00;
    repeat (6) tick();
  endtask

  initial begin
    bus.addr = '0;  bus.writedata = '0;  bus.memwrite = 1'b0;
    bus8.addr = '0; bus8.writedata = '0; bus8.memwrite = 1'b0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_w1c();
    test_leds();
    test_reset_mid();
    test_count_wrap();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_buttons.md
MMIO_BUTTONS -- requirements
Module: mmio_buttons

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0800, word-aligned base of the 16-byte register window.
REQ-002 Parameter N_BTN, default 4, number of button inputs (1..8).
REQ-003 Parameter DEBOUNCE, default 16, stable cycles required before a level change is accepted (>=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 addr  input  32  CPU byte address.
REQ-007 writedata  input  32  CPU store data.
REQ-008 memwrite  input  1  store strobe, sampled on rising clk.
REQ-009 readdata  output  32  register read data, combinational from addr.
REQ-010 hit  output  1  addr lies in [BASE_ADDR, BASE_ADDR+15]; top level muxes readdata on it.
REQ-011 btn  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-012 leds  output  8  LED register contents.

Function
REQ-013 Register map (word offsets, addr[1:0] ignored): 0x0 STATE RO, 0x4 PRESS RW1C, 0x8 COUNT, 0xC LEDS RW.
REQ-014 STATE bits[N_BTN-1:0] = debounced levels; upper bits read 0.
REQ-015 Each btn bit passes a 2-flop synchronizer before any other use.
REQ-016 Per button: counter cleared when sync == stable; incremented when sync != stable; when sync != stable and counter == DEBOUNCE-1, stable <= sync and counter <= 0.
REQ-017 Input change held constant from edge k is reflected in STATE at edge k+2+DEBOUNCE; glitches shorter than DEBOUNCE cycles never change STATE.
REQ-018 PRESS bit i sets on the edge where stable i goes 0->1; stays set until cleared.
REQ-019 Write to PRESS clears bits where writedata is 1; other bits untouched.
REQ-020 Simultaneous set and W1C of the same PRESS bit: set wins (bit = 1).
REQ-021 COUNT bits[15:0] increments by popcount of rising debounced edges that cycle; wraps 16'hFFFF -> 0; upper bits read 0.
REQ-022 Any write to COUNT clears it; rising edges in the same cycle are applied after the clear (result = that cycle's popcount).
REQ-023 Write to LEDS loads writedata[7:0]; leds output equals register, reads back in bits[7:0].
REQ-024 Writes to STATE, and all accesses with hit = 0, have no effect; readdata = 0 when hit = 0.
REQ-025 Write takes effect at the rising edge where memwrite = 1 and hit = 1; readback is visible the next cycle.

Reset
REQ-026 While reset = 0: synchronizers, stable levels, debounce counters, PRESS, COUNT, LEDS all 0; leds = 0 immediately (asynchronously).
REQ-027 Reset asserted mid-debounce discards the pending change; after release, a still-held button re-qualifies with the full 2+DEBOUNCE latency.

Structure
REQ-028 Package mmio_buttons_pkg holds register offsets, default BASE_ADDR/DEBOUNCE constants and the COUNT width.
REQ-029 Sub-module btn_debounce (one synchronizer + counter + stable flop, parameter DEBOUNCE) instantiated N_BTN times via generate.
REQ-030 Register file, address decode and edge detection live in mmio_buttons.

Verification
REQ-031 DEBOUNCE=4: hold btn=4'b0001 from edge 0 -> STATE=1 and PRESS=1 at edge 6, not before; COUNT=1.
REQ-032 DEBOUNCE=4: 3-cycle pulse on btn[1] -> STATE, PRESS, COUNT stay 0.
REQ-033 PRESS=4'b0101, store 32'h1 to BASE+4 -> PRESS=4'b0100; store coinciding with btn[0] debounced rise -> PRESS bit 0 remains 1.
REQ-034 Store 32'h0000_00A5 to BASE+0xC -> leds=8'hA5, read BASE+0xC = 32'hA5; read BASE+0x10 -> hit=0, readdata=0.
REQ-035 Preload COUNT to 16'hFFFF via 65535 presses (or forced), one more press -> COUNT=0; store to BASE+8 with two simultaneous rises -> COUNT=2.
REQ-036 reset=0 for one cycle mid-debounce with btn held -> all outputs 0 at once; STATE rises 2+DEBOUNCE edges after release.
